mips32_dmem_responder: RTL and testbench



---
 rtl/mips32_pkg.sv | 18 +
 rtl/mips32_dmem_responder_if.sv | 34 +++
 rtl/mips32_sram.sv | 35 +++
 rtl/mips32_dmem_responder.sv | 123 ++++++++++++
 tb/tb_mips32_dmem_responder.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 data-memory path.
// Holds the data width, the responder FSM state type and the memory opcode
// encodings used by both the processor decode and the verification bench.
package mips32_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  // Memory opcode encodings shared by the processor and the bench
  localparam logic [3:0] LW = 4'd8;
  localparam logic [3:0] SW = 4'd9;

endpackage

// File: rtl/mips32_dmem_responder_if.sv
// Data-memory request/response bus between the MEM stage (master) and the
// memory responder (slave).
//   req_valid/req_ready  request handshake; req_we=1 store, 0 load
//   req_addr             32-bit word address
//   req_wdata            store data
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            load data (0 for stores and errors)
//   rsp_err              address out of range
//   busy                 responder not idle
interface mips32_dmem_responder_if;
  import mips32_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

endinterface

// File: rtl/mips32_sram.sv
// Single-port synchronous RAM, no reset.
//   clk    clock
//   en     access strobe; one access per asserted cycle
//   we     1 = write wdata to mem[addr], 0 = register mem[addr] into rdata
//   addr   word index
//   wdata  write data
//   rdata  registered read data; holds until the next read access
module mips32_sram #(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mips32_dmem_responder.sv
// Responder end of the MIPS32 data-memory interface.
// Accepts one word load/store at a time, waits WAIT_CYCLES (0..15) cycles,
// performs the memory access on the edge entering RESP and holds the response
// until the requester takes it. Addresses >= DEPTH respond with rsp_err=1 and
// never touch the array.
//   clk  clock (posedge)
//   rst  asynchronous active-high reset
//   bus  request/response bus, slave side
module mips32_dmem_responder
  import mips32_pkg::*;
#(
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic                     clk,
  input logic                     rst,
  mips32_dmem_responder_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  mem_state_t        state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic              err_q;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              accept;
  logic              req_err;
  logic              enter_resp;
  logic              acc_we;
  logic              acc_err;
  logic              mem_en;
  logic [AW-1:0]     acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [DATA_W-1:0] ram_rdata;

  always_comb begin
    accept     = (state_q == IDLE) && bus.req_valid;
    req_err    = (bus.req_addr >= DEPTH);
    enter_resp = (accept && (WAIT_CYCLES == 0)) || ((state_q == WAIT) && (cnt_q == 4'd0));
    // With zero wait states the access happens on the accepting edge, so the
    // RAM must see the live request rather than the captured copy.
    if (state_q == IDLE) begin
      acc_we    = bus.req_we;
      acc_err   = req_err;
      acc_addr  = bus.req_addr[AW-1:0];
      acc_wdata = bus.req_wdata;
    end else begin
      acc_we    = we_q;
      acc_err   = err_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
    mem_en = enter_resp && !acc_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= bus.req_we;
            err_q   <= req_err;
            addr_q  <= bus.req_addr[AW-1:0];
            wdata_q <= bus.req_wdata;
            if (WAIT_CYCLES == 0) begin
              state_q <= RESP;
            end else begin
              cnt_q   <= WAIT_LOAD;
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mips32_sram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_sram (
    .clk   (clk),
    .en    (mem_en),
    .we    (acc_we),
    .addr  (acc_addr),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  // RAM read register is only meaningful for an in-range load in RESP;
  // everywhere else the data output reads as zero.
  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_err   = (state_q == RESP) && err_q;
  assign bus.rsp_rdata = ((state_q == RESP) && !we_q && !err_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_mips32_dmem_responder.sv
module tb_mips32_dmem_responder;
  import mips32_pkg::*;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips32_dmem_responder_if bus ();
  mips32_dmem_responder_if bus0 ();

  mips32_dmem_responder #(.DEPTH(512), .WAIT_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mips32_dmem_responder #(.DEPTH(512), .WAIT_CYCLES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  exp_t        sb[$];
  logic [31:0] model [512];
  int          checks    = 0;
  int          failures  = 0;
  int          cyc       = 0;
  int          bp_mode   = 0;  // 0 ready, 1 random, 2 held low
  int          n_issued  = 0;
  int          n_rsp     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Response monitor and rsp_ready driver for the WAIT_CYCLES=2 instance
  initial begin : mon
    bit prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      case (bp_mode)
        0:       bus.rsp_ready = 1'b1;
        1:       bus.rsp_ready = 1'($urandom_range(0, 1));
        default: bus.rsp_ready = 1'b0;
      endcase
      if (rst) begin
        prev_valid = 1'b0;
        continue;
      end
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          check_eq("spurious_rsp", 32'd1, 32'd0);
        end else begin
          if (!prev_valid) check_eq("latency", cyc - sb[0].acc, 32'd2);
          check_eq("rsp_rdata", bus.rsp_rdata, sb[0].rdata);
          check_eq("rsp_err", bus.rsp_err, sb[0].err);
          check_eq("req_ready_in_resp", bus.req_ready, 32'd0);
          if (bus.rsp_ready) begin
            void'(sb.pop_front());
            n_rsp++;
          end
        end
      end
      prev_valid = bus.rsp_valid;
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = (op == SW);
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check_eq("accept_timeout", 32'd1, 32'd0);
      bus.req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    e.acc   = cyc;
    e.err   = (addr >= 32'd512);
    e.rdata = 32'd0;
    if (!e.err) begin
      if (op == SW) model[addr[8:0]] = wd;
      else          e.rdata = model[addr[8:0]];
    end
    sb.push_back(e);
    n_issued++;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check_eq("drain_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] old;
    logic [31:0] a;
    int          n;
    int          r;
    logic [3:0]  op;

    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus0.req_valid = 1'b0;
    bus0.req_we    = 1'b0;
    bus0.req_addr  = '0;
    bus0.req_wdata = '0;
    bus0.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", bus.req_ready, 32'd1);
    check_eq("rst_rsp_valid", bus.rsp_valid, 32'd0);
    check_eq("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check_eq("rst_rsp_err", bus.rsp_err, 32'd0);
    check_eq("rst_busy", bus.busy, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", bus.req_ready, 32'd1);

    // Store then load, two wait states
    issue(SW, 32'd5, 32'hDEAD_BEEF);
    issue(LW, 32'd5, 32'd0);
    wait_drain();

    // Known contents for the addresses used later
    for (int i = 0; i < 16; i++) issue(SW, i, $urandom);
    issue(SW, 32'd511, 32'h11);
    issue(SW, 32'd7, 32'h22);
    wait_drain();

    // Out-of-range accesses must not disturb the array
    issue(LW, 32'd512, 32'd0);
    issue(SW, 32'hFFFF_FFFF, 32'h0000_ABCD);
    issue(LW, 32'd511, 32'd0);
    wait_drain();

    // Backpressure: response frozen, stray requests ignored
    bp_mode = 2;
    issue(LW, 32'd3, 32'd0);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("hold_rsp_seen", bus.rsp_valid, 32'd1);
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'd3;
    bus.req_wdata = 32'h0000_0BAD;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.req_valid = ~bus.req_valid;
      check_eq("hold_busy", bus.busy, 32'd1);
      check_eq("hold_rsp_valid", bus.rsp_valid, 32'd1);
    end
    bus.req_valid = 1'b0;
    bp_mode = 0;
    wait_drain();
    issue(LW, 32'd3, 32'd0);
    wait_drain();

    // Reset during WAIT of a store drops it
    old = model[7];
    issue(SW, 32'd7, 32'h55);
    rst = 1'b1;
    #1;
    check_eq("wrst_req_ready", bus.req_ready, 32'd1);
    check_eq("wrst_rsp_valid", bus.rsp_valid, 32'd0);
    check_eq("wrst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check_eq("wrst_rsp_err", bus.rsp_err, 32'd0);
    check_eq("wrst_busy", bus.busy, 32'd0);
    sb.delete();
    model[7] = old;
    n_issued--;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("wrst_post_ready", bus.req_ready, 32'd1);
    issue(LW, 32'd7, 32'd0);
    wait_drain();

    // Random mix with random backpressure
    bp_mode = 1;
    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 19);
      op = ($urandom_range(0, 1) == 1) ? SW : LW;
      if (r < 16)       a = r;
      else if (r == 16) a = 32'd511;
      else if (r == 17) a = 32'd512;
      else if (r == 18) a = $urandom | 32'h8000_0000;
      else              a = 32'd1000;
      issue(op, a, $urandom);
    end
    wait_drain();
    bp_mode = 0;
    wait_drain();
    check_eq("rsp_count", n_rsp, n_issued);

    // Zero wait states: back-to-back stores then loads, one-cycle latency
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("w0_idle_ready", bus0.req_ready, 32'd1);
      check_eq("w0_idle_valid", bus0.rsp_valid, 32'd0);
      bus0.req_valid = 1'b1;
      bus0.req_we    = (i < 4);
      bus0.req_addr  = i % 4;
      bus0.req_wdata = i + 1;
      @(negedge clk);
      check_eq("w0_rsp_valid", bus0.rsp_valid, 32'd1);
      check_eq("w0_req_ready", bus0.req_ready, 32'd0);
      check_eq("w0_busy", bus0.busy, 32'd1);
      check_eq("w0_rsp_rdata", bus0.rsp_rdata, (i < 4) ? 32'd0 : 32'(i - 3));
      check_eq("w0_rsp_err", bus0.rsp_err, 32'd0);
    end
    bus0.req_valid = 1'b0;
    @(negedge clk);
    check_eq("w0_final_idle", bus0.busy, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
